// File: rtl/uart_rx_fsm.sv
// UART receiver frame controller.
// Tracks one serial frame (start, WIDTH data bits, optional parity, stop) on the
// oversampling clock. Runs the edge and bit counters, enables the sampler and checkers
// for the bit currently on the line, and reports the frame outcome as a one-cycle pulse.
module uart_rx_fsm #(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               FSM_RX_IN,
    input  logic [PRESC_W-1:0] FSM_Prescale,
    input  logic               FSM_PAR_EN,
    input  logic               FSM_Sample_Valid,
    input  logic               FSM_Strt_Glitch,
    input  logic               FSM_Par_Err,
    input  logic               FSM_Stp_Err_In,
    output logic [PRESC_W-1:0] FSM_Edge_Cnt,
    output logic               FSM_Samp_EN,
    output logic               FSM_Strt_Chk_EN,
    output logic               FSM_Deser_EN,
    output logic               FSM_Par_Chk_EN,
    output logic               FSM_Stp_Chk_EN,
    output logic               FSM_Data_Valid,
    output logic               FSM_Par_Err_Out,
    output logic               FSM_Stp_Err
);

    // Bit counter must be able to hold WIDTH itself (count of bits already shifted).
    localparam int BIT_W = $clog2(WIDTH + 1);

    localparam logic [BIT_W-1:0]   BIT_ONE  = BIT_W'(1);
    localparam logic [BIT_W-1:0]   LAST_BIT = BIT_W'(WIDTH - 1);
    localparam logic [PRESC_W-1:0] EDGE_ONE = PRESC_W'(1);

    // Frame states.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [PRESC_W-1:0] r_edge_cnt;
    logic [PRESC_W-1:0] w_edge_cnt_next;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [BIT_W-1:0]   w_bit_cnt_next;

    // Frame configuration captured when a start edge is accepted, so that the
    // configuration inputs may change freely while a frame is in flight.
    logic [PRESC_W-1:0] r_prescale;
    logic               r_par_en;

    logic               r_data_valid;
    logic               r_par_err;
    logic               r_stp_err;

    logic               w_bit_end;
    logic               w_start_entry;
    logic               w_deser_stb;
    logic               w_last_bit;
    logic               w_rest_state;

    // Last oversampling edge of the current bit period, against the latched ratio.
    assign w_bit_end     = (r_edge_cnt == (r_prescale - EDGE_ONE));

    // IDLE and DONE are the only states that watch the line for a new start edge.
    assign w_rest_state  = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_start_entry = w_rest_state && !FSM_RX_IN;

    // A data bit is only consumed when the sampler has a voted value at bit end;
    // otherwise the same bit period is retried without advancing the bit counter.
    assign w_deser_stb   = (r_state == S_DATA) && w_bit_end && FSM_Sample_Valid;
    assign w_last_bit    = (r_bit_cnt == LAST_BIT);

    // Next-state decision for the frame sequencer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!FSM_RX_IN) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_next = FSM_Strt_Glitch ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_deser_stb && w_last_bit) begin
                    w_state_next = r_par_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = FSM_Par_Err ? S_IDLE : S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_state_next = FSM_Stp_Err_In ? S_IDLE : S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = FSM_RX_IN ? S_IDLE : S_START;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Edge counter: parked at 0 between frames, otherwise counts modulo the ratio.
    always_comb begin
        w_edge_cnt_next = r_edge_cnt + EDGE_ONE;
        if (w_rest_state || w_bit_end) begin
            w_edge_cnt_next = '0;
        end
    end

    // Bit counter: cleared when a frame starts, advanced once per accepted data bit.
    always_comb begin
        w_bit_cnt_next = r_bit_cnt;
        if (w_start_entry) begin
            w_bit_cnt_next = '0;
        end else if (w_deser_stb) begin
            w_bit_cnt_next = r_bit_cnt + BIT_ONE;
        end
    end

    // State and counter registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= S_IDLE;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_edge_cnt <= w_edge_cnt_next;
            r_bit_cnt  <= w_bit_cnt_next;
        end
    end

    // Capture frame configuration on every accepted start edge, including back-to-back.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_prescale <= '0;
            r_par_en   <= 1'b0;
        end else if (w_start_entry) begin
            r_prescale <= FSM_Prescale;
            r_par_en   <= FSM_PAR_EN;
        end
    end

    // Outcome pulses, registered so they line up with DONE/IDLE entry.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
        end else begin
            r_data_valid <= (r_state == S_STOP)   && w_bit_end && !FSM_Stp_Err_In;
            r_par_err    <= (r_state == S_PARITY) && w_bit_end && FSM_Par_Err;
            r_stp_err    <= (r_state == S_STOP)   && w_bit_end && FSM_Stp_Err_In;
        end
    end

    // Sampler and checker enables decoded directly from the current state.
    always_comb begin
        FSM_Samp_EN     = 1'b0;
        FSM_Strt_Chk_EN = 1'b0;
        FSM_Par_Chk_EN  = 1'b0;
        FSM_Stp_Chk_EN  = 1'b0;
        case (r_state)
            S_START: begin
                FSM_Samp_EN     = 1'b1;
                FSM_Strt_Chk_EN = 1'b1;
            end
            S_DATA: begin
                FSM_Samp_EN     = 1'b1;
            end
            S_PARITY: begin
                FSM_Samp_EN     = 1'b1;
                FSM_Par_Chk_EN  = 1'b1;
            end
            S_STOP: begin
                FSM_Samp_EN     = 1'b1;
                FSM_Stp_Chk_EN  = 1'b1;
            end
            default: begin
                FSM_Samp_EN     = 1'b0;
            end
        endcase
    end

    assign FSM_Edge_Cnt    = r_edge_cnt;
    assign FSM_Deser_EN    = w_deser_stb;
    assign FSM_Data_Valid  = r_data_valid;
    assign FSM_Par_Err_Out = r_par_err;
    assign FSM_Stp_Err     = r_stp_err;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for the UART receiver frame controller. The checker/sampler inputs
// are driven as static levels per scenario; a negedge monitor counts strobes, enables
// and outcome pulses, which are compared against hand-computed frame figures.
module tb_uart_rx_fsm;

    logic       CLK = 1'b0;
    logic       RST;
    logic       FSM_RX_IN;
    logic [5:0] FSM_Prescale;
    logic       FSM_PAR_EN;
    logic       FSM_Sample_Valid;
    logic       FSM_Strt_Glitch;
    logic       FSM_Par_Err;
    logic       FSM_Stp_Err_In;
    logic [5:0] FSM_Edge_Cnt;
    logic       FSM_Samp_EN;
    logic       FSM_Strt_Chk_EN;
    logic       FSM_Deser_EN;
    logic       FSM_Par_Chk_EN;
    logic       FSM_Stp_Chk_EN;
    logic       FSM_Data_Valid;
    logic       FSM_Par_Err_Out;
    logic       FSM_Stp_Err;

    uart_rx_fsm #(.WIDTH(8), .PRESC_W(6)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .FSM_RX_IN        (FSM_RX_IN),
        .FSM_Prescale     (FSM_Prescale),
        .FSM_PAR_EN       (FSM_PAR_EN),
        .FSM_Sample_Valid (FSM_Sample_Valid),
        .FSM_Strt_Glitch  (FSM_Strt_Glitch),
        .FSM_Par_Err      (FSM_Par_Err),
        .FSM_Stp_Err_In   (FSM_Stp_Err_In),
        .FSM_Edge_Cnt     (FSM_Edge_Cnt),
        .FSM_Samp_EN      (FSM_Samp_EN),
        .FSM_Strt_Chk_EN  (FSM_Strt_Chk_EN),
        .FSM_Deser_EN     (FSM_Deser_EN),
        .FSM_Par_Chk_EN   (FSM_Par_Chk_EN),
        .FSM_Stp_Chk_EN   (FSM_Stp_Chk_EN),
        .FSM_Data_Valid   (FSM_Data_Valid),
        .FSM_Par_Err_Out  (FSM_Par_Err_Out),
        .FSM_Stp_Err      (FSM_Stp_Err)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Cycle index, advanced on every active edge.
    int cyc = 0;
    always @(posedge CLK) cyc++;

    // Monitor counters, cleared at the start of each scenario.
    int n_strobe, n_valid, n_perr, n_serr;
    int n_strtchk, n_parchk, n_stpchk, n_timing, n_multi;
    int first_pulse, last_pulse;
    int exp_p = 8;

    always @(negedge CLK) begin
        int pulses;
        if (RST) begin
            if (FSM_Deser_EN) begin
                n_strobe++;
                if (int'(FSM_Edge_Cnt) != exp_p - 1) n_timing++;
            end
            if (FSM_Data_Valid)  n_valid++;
            if (FSM_Par_Err_Out) n_perr++;
            if (FSM_Stp_Err)     n_serr++;
            if (FSM_Strt_Chk_EN) n_strtchk++;
            if (FSM_Par_Chk_EN)  n_parchk++;
            if (FSM_Stp_Chk_EN)  n_stpchk++;
            pulses = int'(FSM_Data_Valid) + int'(FSM_Par_Err_Out) + int'(FSM_Stp_Err);
            if (pulses > 1) n_multi++;
            if (pulses != 0) begin
                if (first_pulse < 0) first_pulse = cyc;
                last_pulse = cyc;
            end
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_counts(input int p);
        exp_p       = p;
        n_strobe    = 0; n_valid  = 0; n_perr   = 0; n_serr = 0;
        n_strtchk   = 0; n_parchk = 0; n_stpchk = 0;
        n_timing    = 0; n_multi  = 0;
        first_pulse = -1; last_pulse = -1;
    endtask

    task automatic drive_bit(input logic b, input int p);
        FSM_RX_IN = b;
        repeat (p) step();
    endtask

    // Serial frame on the line: start, data LSB first, optional parity, stop.
    task automatic send_frame(input int p, input logic [7:0] d, input bit par_en,
                              input bit par_bit, input bit stop_bit);
        drive_bit(1'b0, p);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (par_en) drive_bit(par_bit, p);
        drive_bit(stop_bit, p);
        FSM_RX_IN = 1'b1;
    endtask

    function automatic int outputs_word();
        return int'({FSM_Edge_Cnt, FSM_Samp_EN, FSM_Strt_Chk_EN, FSM_Deser_EN,
                     FSM_Par_Chk_EN, FSM_Stp_Chk_EN, FSM_Data_Valid,
                     FSM_Par_Err_Out, FSM_Stp_Err});
    endfunction

    task automatic report(input string name);
        $display("frame %s: strobes=%0d valid=%0d par_err=%0d stp_err=%0d first_pulse=%0d",
                 name, n_strobe, n_valid, n_perr, n_serr, first_pulse);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int t0;
        int waited;
        RST = 1'b0;
        FSM_RX_IN = 1'b1; FSM_Prescale = 6'd8; FSM_PAR_EN = 1'b0;
        FSM_Sample_Valid = 1'b1; FSM_Strt_Glitch = 1'b0;
        FSM_Par_Err = 1'b0; FSM_Stp_Err_In = 1'b0;
        clear_counts(8);
        repeat (3) step();
        check_eq("reset_outputs", outputs_word(), 0);
        RST = 1'b1;
        repeat (3) step();
        check_eq("idle_outputs", outputs_word(), 0);

        // 1: 8N1 0xA5 at x8; configuration changed mid-frame must be ignored.
        clear_counts(8);
        t0 = cyc;
        fork
            send_frame(8, 8'hA5, 1'b0, 1'b0, 1'b1);
            begin
                repeat (20) step();
                FSM_PAR_EN = 1'b1;
                FSM_Prescale = 6'd16;
            end
        join
        repeat (24) step();
        report("t1_a5");
        check_eq("t1_strobes", n_strobe, 8);
        check_eq("t1_valid", n_valid, 1);
        check_eq("t1_errs", n_perr + n_serr, 0);
        check_eq("t1_strt_chk_cycles", n_strtchk, 8);
        check_eq("t1_par_chk_cycles", n_parchk, 0);
        check_eq("t1_stp_chk_cycles", n_stpchk, 8);
        check_eq("t1_latency", first_pulse - t0, 81);
        check_eq("t1_strobe_timing", n_timing, 0);

        // 2: x16 with parity, parity checker reports an error.
        FSM_Prescale = 6'd16; FSM_PAR_EN = 1'b1; FSM_Par_Err = 1'b1;
        clear_counts(16);
        t0 = cyc;
        send_frame(16, 8'h3C, 1'b1, 1'b1, 1'b1);
        repeat (32) step();
        report("t2_3c_parerr");
        check_eq("t2_strobes", n_strobe, 8);
        check_eq("t2_par_err", n_perr, 1);
        check_eq("t2_valid", n_valid, 0);
        check_eq("t2_stp_err", n_serr, 0);
        check_eq("t2_par_chk_cycles", n_parchk, 16);
        check_eq("t2_stp_chk_cycles", n_stpchk, 0);
        check_eq("t2_latency", first_pulse - t0, 161);
        check_eq("t2_idle_samp_en", int'(FSM_Samp_EN), 0);
        check_eq("t2_strobe_timing", n_timing, 0);
        FSM_Par_Err = 1'b0; FSM_PAR_EN = 1'b0;

        // 3: short low glitch at x8, start checker flags it.
        FSM_Prescale = 6'd8; FSM_Strt_Glitch = 1'b1;
        clear_counts(8);
        drive_bit(1'b0, 3);
        drive_bit(1'b1, 24);
        report("t3_glitch");
        check_eq("t3_strt_chk_cycles", n_strtchk, 8);
        check_eq("t3_strobes", n_strobe, 0);
        check_eq("t3_pulses", n_valid + n_perr + n_serr, 0);
        check_eq("t3_idle_outputs", outputs_word(), 0);
        FSM_Strt_Glitch = 1'b0;

        // 4: framing error at x32.
        FSM_Prescale = 6'd32; FSM_Stp_Err_In = 1'b1;
        clear_counts(32);
        t0 = cyc;
        send_frame(32, 8'h81, 1'b0, 1'b0, 1'b0);
        repeat (40) step();
        report("t4_stperr");
        check_eq("t4_strobes", n_strobe, 8);
        check_eq("t4_stp_err", n_serr, 1);
        check_eq("t4_valid", n_valid, 0);
        check_eq("t4_latency", first_pulse - t0, 321);
        check_eq("t4_strobe_timing", n_timing, 0);
        FSM_Stp_Err_In = 1'b0;

        // 5: two back-to-back frames at x8.
        FSM_Prescale = 6'd8;
        clear_counts(8);
        t0 = cyc;
        send_frame(8, 8'h55, 1'b0, 1'b0, 1'b1);
        send_frame(8, 8'hAA, 1'b0, 1'b0, 1'b1);
        repeat (24) step();
        report("t5_b2b");
        check_eq("t5_strobes", n_strobe, 16);
        check_eq("t5_valid", n_valid, 2);
        check_eq("t5_first_latency", first_pulse - t0, 81);
        check_eq("t5_second_latency", last_pulse - t0, 162);
        check_eq("t5_errs", n_perr + n_serr, 0);

        // 6: reset in the middle of the data bits, then a clean frame.
        clear_counts(8);
        drive_bit(1'b0, 8);
        FSM_RX_IN = 1'b1;
        waited = 0;
        while (n_strobe < 4 && waited < 200) begin
            step();
            waited++;
        end
        check_eq("t6_reached_4_bits", int'(n_strobe >= 4), 1);
        repeat (3) step();
        check_eq("t6_in_data", int'(FSM_Samp_EN), 1);
        RST = 1'b0;
        #1;
        check_eq("t6_reset_outputs", outputs_word(), 0);
        repeat (2) step();
        RST = 1'b1;
        repeat (60) step();
        check_eq("t6_aborted_pulses", n_valid + n_perr + n_serr, 0);
        clear_counts(8);
        t0 = cyc;
        send_frame(8, 8'h5A, 1'b0, 1'b0, 1'b1);
        repeat (24) step();
        report("t6_after_reset");
        check_eq("t6_strobes", n_strobe, 8);
        check_eq("t6_valid", n_valid, 1);
        check_eq("t6_latency", first_pulse - t0, 81);

        // 7: sampler not ready at the first data bit end; that bit period is retried.
        clear_counts(8);
        t0 = cyc;
        fork
            send_frame(8, 8'hC3, 1'b0, 1'b0, 1'b1);
            begin
                repeat (12) step();
                FSM_Sample_Valid = 1'b0;
                repeat (8) step();
                FSM_Sample_Valid = 1'b1;
            end
        join
        repeat (24) step();
        report("t7_retry");
        check_eq("t7_strobes", n_strobe, 8);
        check_eq("t7_valid", n_valid, 1);
        check_eq("t7_latency", first_pulse - t0, 89);
        check_eq("t7_strobe_timing", n_timing, 0);

        check_eq("pulse_exclusive", n_multi, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
